prog_mem_loader: RTL and testbench
==================================

PROG_MEM_LOADER -- requirements
Module: prog_mem_loader

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 8, memory byte-lane width in bits.
REQ-002 SHALL have parameter ADDWIDTH, default 7, byte-address width; depth = 2**ADDWIDTH bytes.
REQ-003 SHALL have parameter INSTR_BYTES, default 4, bytes per fetched instruction, little-endian, legal values 1, 2 and 4.
REQ-004 SHALL have one clock and an asynchronous, active-high reset, with ports ordered as follows:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous active-high reset.
REQ-005 SHALL have the load and fetch ports below:
- load_start  in  1  pulse: begin load at load_base.
- load_base  in  ADDWIDTH  load start byte address.
- ld_valid  in  1  load byte valid.
- ld_data  in  DATAWIDTH  load byte.
- ld_last  in  1  final byte of stream, qualified by ld_valid.
- ld_ready  out  1  loader accepts a byte.
- fetch_req  in  1  instruction fetch request.
- readAdd  in  ADDWIDTH  fetch byte address.
- instruction  out  DATAWIDTH*INSTR_BYTES  fetched word.
- instr_valid  out  1  instruction valid.
- misaligned  out  1  the last fetch had readAdd not a multiple of INSTR_BYTES.
- busy  out  1  load in progress.
- load_count  out  ADDWIDTH+1  bytes written in the last or current load.

Function
REQ-006 SHALL implement FSM states IDLE, LOAD and DONE; DONE SHALL last exactly one cycle, then the FSM SHALL return to IDLE.
REQ-007 In IDLE or DONE, load_start SHALL latch load_base into the write pointer, clear load_count, and enter LOAD the next cycle.
REQ-008 ld_ready SHALL be 1 only in LOAD; a byte SHALL transfer on a cycle with ld_valid && ld_ready.
REQ-009 Each transfer SHALL write ld_data to mem[wptr], increment wptr modulo 2**ADDWIDTH (wrap 127->0), and increment load_count, saturating at 2**ADDWIDTH.
REQ-010 A transfer with ld_last=1 SHALL be written, and the FSM SHALL go to DONE the next cycle.
REQ-011 load_start while in LOAD SHALL be ignored.
REQ-012 busy SHALL equal (state==LOAD).
REQ-013 Fetch SHALL be registered with one-cycle latency: fetch_req at edge N gives instruction and instr_valid=1 after edge N+1; instr_valid=0 otherwise.
REQ-014 instruction SHALL be {mem[A+INSTR_BYTES-1],...,mem[A]}, where each byte address is computed modulo 2**ADDWIDTH.
REQ-015 fetch_req while busy=1 SHALL be ignored: instr_valid stays 0 and instruction holds its previous value.
REQ-016 instruction SHALL hold its value when no fetch is accepted.
REQ-017 misaligned SHALL be registered together with instruction; a misaligned fetch SHALL still return data.
REQ-018 A fetch in DONE SHALL see all bytes of the completed load.

Reset
REQ-019 rst=1 SHALL asynchronously force: state=IDLE, wptr=0, load_count=0, instruction=0, instr_valid=0, misaligned=0, ld_ready=0, busy=0.
REQ-020 Memory contents SHALL NOT be reset.
REQ-021 Reset during LOAD SHALL abort the load; bytes already written SHALL remain.

Configuration
REQ-022 Macro PROG_MEM_CHECKSUM_EN SHALL control a checksum feature.
- Defined: adds output checksum [DATAWIDTH-1:0] = XOR of all bytes accepted since the last load_start; it is cleared by load_start and by rst.
- Undefined: no checksum port, and no checksum logic.

Verification
REQ-023 Reset: assert rst mid-cycle -> all outputs 0 immediately, without waiting for a clock edge.
REQ-024 Load then fetch:
- Stimulus: load_base=0; bytes 0x13,0x00,0x50,0x00 with ld_last on the 4th; then fetch readAdd=0.
- Response: instruction=0x00500013 one cycle later, instr_valid=1, misaligned=0, load_count=4.
REQ-025 Back-pressure: ld_valid high from the cycle load_start is asserted -> no write until ld_ready=1; bytes written in order, none lost.
REQ-026 Wrap-around: load_base=126, 4 bytes AA,BB,CC,DD -> mem[126]=AA, mem[127]=BB, mem[0]=CC, mem[1]=DD; fetch readAdd=126 -> 0xDDCCBBAA.
REQ-027 Conflicts:
- fetch_req during LOAD -> instr_valid=0.
- load_start during LOAD -> wptr unchanged.
- fetch readAdd=2 -> misaligned=1.
REQ-028 With PROG_MEM_CHECKSUM_EN defined: load bytes 0x13,0x00,0x50,0x00 -> checksum=0x43; a new load_start -> checksum=0x00.

Source files
------------

// File: rtl/prog_mem_loader_if.sv
// Load-stream and instruction-fetch bus for prog_mem_loader.
// The checksum output exists only when PROG_MEM_CHECKSUM_EN is defined.
interface prog_mem_loader_if #(
    parameter int DATAWIDTH   = 8,
    parameter int ADDWIDTH    = 7,
    parameter int INSTR_BYTES = 4
);
    logic                             load_start;
    logic [ADDWIDTH-1:0]              load_base;
    logic                             ld_valid;
    logic [DATAWIDTH-1:0]             ld_data;
    logic                             ld_last;
    logic                             ld_ready;
    logic                             fetch_req;
    logic [ADDWIDTH-1:0]              readAdd;
    logic [DATAWIDTH*INSTR_BYTES-1:0] instruction;
    logic                             instr_valid;
    logic                             misaligned;
    logic                             busy;
    logic [ADDWIDTH:0]                load_count;
`ifdef PROG_MEM_CHECKSUM_EN
    logic [DATAWIDTH-1:0]             checksum;
`endif

    modport master (
`ifdef PROG_MEM_CHECKSUM_EN
        input  checksum,
`endif
        output load_start, load_base, ld_valid, ld_data, ld_last,
        output fetch_req, readAdd,
        input  ld_ready, instruction, instr_valid, misaligned, busy, load_count
    );

    modport slave (
`ifdef PROG_MEM_CHECKSUM_EN
        output checksum,
`endif
        input  load_start, load_base, ld_valid, ld_data, ld_last,
        input  fetch_req, readAdd,
        output ld_ready, instruction, instr_valid, misaligned, busy, load_count
    );
endinterface

// File: rtl/prog_mem_loader.sv
// Program memory with a streaming byte loader and a registered little-endian fetch port.
// Optional feature: define PROG_MEM_CHECKSUM_EN for an XOR checksum of the loaded bytes.
module prog_mem_loader #(
    parameter int DATAWIDTH   = 8,
    parameter int ADDWIDTH    = 7,
    parameter int INSTR_BYTES = 4
) (
    input  logic             clk,
    input  logic             rst,
    prog_mem_loader_if.slave bus
);
    localparam int DEPTH = 2**ADDWIDTH;
    localparam int WORDW = DATAWIDTH*INSTR_BYTES;
    localparam logic [ADDWIDTH:0]   COUNT_MAX  = (ADDWIDTH+1)'(DEPTH);
    localparam logic [ADDWIDTH-1:0] ALIGN_MASK = ADDWIDTH'(INSTR_BYTES-1);

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t              state_q, state_d;
    logic [ADDWIDTH-1:0] wptr_q, wptr_d;
    logic [ADDWIDTH:0]   count_q, count_d;
    logic [WORDW-1:0]    instr_q, rd_word;
    logic                instr_valid_q, misaligned_q;
    logic                start_acc, xfer, fetch_acc, ld_ready;

    logic [DATAWIDTH-1:0] mem_q [DEPTH];

    assign xfer      = bus.ld_valid && ld_ready;
    assign fetch_acc = bus.fetch_req && (state_q != LOAD);

    always_comb begin
        state_d   = state_q;
        wptr_d    = wptr_q;
        count_d   = count_q;
        ld_ready  = 1'b0;
        start_acc = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.load_start) begin
                    start_acc = 1'b1;
                    wptr_d    = bus.load_base;
                    count_d   = '0;
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                ld_ready = 1'b1;
                if (bus.ld_valid) begin
                    wptr_d = wptr_q + 1'b1;
                    if (count_q != COUNT_MAX)
                        count_d = count_q + 1'b1;
                    if (bus.ld_last)
                        state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
        end
    end

    // Storage is deliberately outside the reset domain so a reset keeps loaded code.
    always_ff @(posedge clk) begin
        if (xfer)
            mem_q[wptr_q] <= bus.ld_data;
    end

    generate
        for (genvar gi = 0; gi < INSTR_BYTES; gi++) begin : g_lane
            logic [ADDWIDTH-1:0] lane_addr;
            assign lane_addr = bus.readAdd + ADDWIDTH'(gi);
            assign rd_word[gi*DATAWIDTH +: DATAWIDTH] = mem_q[lane_addr];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            misaligned_q  <= 1'b0;
        end else begin
            instr_valid_q <= fetch_acc;
            if (fetch_acc) begin
                instr_q      <= rd_word;
                misaligned_q <= |(bus.readAdd & ALIGN_MASK);
            end
        end
    end

`ifdef PROG_MEM_CHECKSUM_EN
    logic [DATAWIDTH-1:0] csum_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            csum_q <= '0;
        else if (start_acc)
            csum_q <= '0;
        else if (xfer)
            csum_q <= csum_q ^ bus.ld_data;
    end

    assign bus.checksum = csum_q;
`else
`endif

    assign bus.ld_ready    = ld_ready;
    assign bus.busy        = (state_q == LOAD);
    assign bus.load_count  = count_q;
    assign bus.instruction = instr_q;
    assign bus.instr_valid = instr_valid_q;
    assign bus.misaligned  = misaligned_q;
endmodule

// File: tb/tb_prog_mem_loader.sv
// Directed bench for prog_mem_loader: reset, load/fetch, back-pressure, wrap and conflicts.
module tb_prog_mem_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    prog_mem_loader_if #(.DATAWIDTH(8), .ADDWIDTH(7), .INSTR_BYTES(4)) bus ();

    prog_mem_loader #(.DATAWIDTH(8), .ADDWIDTH(7), .INSTR_BYTES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %s: observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input logic [6:0] base);
        bus.load_start = 1'b1;
        bus.load_base  = base;
        tick();
        bus.load_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] data, input logic last);
        bus.ld_valid = 1'b1;
        bus.ld_data  = data;
        bus.ld_last  = last;
        tick();
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
    endtask

    task automatic fetch(input logic [6:0] addr);
        bus.fetch_req = 1'b1;
        bus.readAdd   = addr;
        tick();
        bus.fetch_req = 1'b0;
    endtask

    initial begin
        bus.load_start = 1'b0;
        bus.load_base  = '0;
        bus.ld_valid   = 1'b0;
        bus.ld_data    = '0;
        bus.ld_last    = 1'b0;
        bus.fetch_req  = 1'b0;
        bus.readAdd    = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_ld_ready",    32'(bus.ld_ready),    32'd0);
        check("rst_busy",        32'(bus.busy),        32'd0);
        check("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
        check("rst_instruction", bus.instruction,      32'd0);
        check("rst_misaligned",  32'(bus.misaligned),  32'd0);
        check("rst_load_count",  32'(bus.load_count),  32'd0);

        // Basic load of addi-like word then fetch while in DONE
        start_load(7'd0);
        check("load_busy",     32'(bus.busy),     32'd1);
        check("load_ld_ready", 32'(bus.ld_ready), 32'd1);
        send_byte(8'h13, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h50, 1'b0);
        send_byte(8'h00, 1'b1);
        check("done_ld_ready", 32'(bus.ld_ready), 32'd0);
        check("done_busy",     32'(bus.busy),     32'd0);
`ifdef PROG_MEM_CHECKSUM_EN
        check("checksum_load", 32'(bus.checksum), 32'h43);
`endif
        fetch(7'd0);
        check("f0_instruction", bus.instruction,     32'h0050_0013);
        check("f0_valid",       32'(bus.instr_valid), 32'd1);
        check("f0_misaligned",  32'(bus.misaligned),  32'd0);
        check("f0_load_count",  32'(bus.load_count),  32'd4);
        tick();
        check("hold_valid",       32'(bus.instr_valid), 32'd0);
        check("hold_instruction", bus.instruction,      32'h0050_0013);

        // Asynchronous reset in the middle of a cycle
        #2 rst = 1'b1;
        #1;
        check("arst_instruction", bus.instruction,     32'd0);
        check("arst_load_count",  32'(bus.load_count), 32'd0);
        check("arst_busy",        32'(bus.busy),       32'd0);
        check("arst_ld_ready",    32'(bus.ld_ready),   32'd0);
        tick();
        rst = 1'b0;

        // Back-pressure: byte presented together with load_start
        bus.ld_valid   = 1'b1;
        bus.ld_data    = 8'h11;
        bus.load_start = 1'b1;
        bus.load_base  = 7'h10;
        tick();
        bus.load_start = 1'b0;
        check("bp_count_0", 32'(bus.load_count), 32'd0);
`ifdef PROG_MEM_CHECKSUM_EN
        check("checksum_clear", 32'(bus.checksum), 32'h00);
`endif
        tick();
        check("bp_count_1", 32'(bus.load_count), 32'd1);
        bus.ld_data   = 8'h22;
        bus.fetch_req = 1'b1;
        bus.readAdd   = 7'd0;
        tick();
        bus.fetch_req = 1'b0;
        check("busy_fetch_valid", 32'(bus.instr_valid), 32'd0);
        check("busy_fetch_instr", bus.instruction,      32'd0);
        bus.ld_data    = 8'h33;
        bus.load_start = 1'b1;
        bus.load_base  = 7'h50;
        tick();
        bus.load_start = 1'b0;
        send_byte(8'h44, 1'b1);
        check("bp_load_count", 32'(bus.load_count), 32'd4);
        fetch(7'h10);
        check("bp_instruction", bus.instruction,     32'h4433_2211);
        check("bp_valid",       32'(bus.instr_valid), 32'd1);

        // Address wrap at the top of memory
        start_load(7'd126);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        send_byte(8'hCC, 1'b0);
        send_byte(8'hDD, 1'b1);
        fetch(7'd126);
        check("wrap_instruction", bus.instruction,    32'hDDCC_BBAA);
        check("wrap_misaligned",  32'(bus.misaligned), 32'd1);
        fetch(7'd0);
        check("wrap_low_instr",      bus.instruction,    32'h0050_DDCC);
        check("wrap_low_misaligned", 32'(bus.misaligned), 32'd0);

        // Short load then a misaligned fetch spanning two loads
        start_load(7'd4);
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b1);
        check("short_load_count", 32'(bus.load_count), 32'd2);
        fetch(7'd2);
        check("mis_instruction", bus.instruction,    32'h0201_0050);
        check("mis_misaligned",  32'(bus.misaligned), 32'd1);
        check("mis_valid",       32'(bus.instr_valid), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
